serial_sub_unit: RTL and testbench

- Bit-serial subtractor, LSB first: computes a − b − bin over WIDTH bits at one bit per clock.
- Produces the WIDTH-bit difference and a borrow-out.
- Sequential counterpart to the small parallel adder benchmarks in the suite; usable as their arithmetic inverse and as a self-checking companion in synthesis/mapping experiments.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/serial_sub_unit.sv | 118 +++++++++++
 tb/tb_serial_sub_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_unit.sv
// serial_sub_unit: bit-serial subtractor, LSB first.
// Computes diff = (a - b - bin) mod 2^WIDTH and bout = (a < b + bin), one bit
// per clock, with a valid/ready handshake on both sides. Only one operation is
// in flight at a time.
//
// State table:
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   SHIFT | one difference bit per edge, counter counts down to terminal 1
//   DONE  | result held on diff/bout with out_valid=1 until out_ready
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands present on a, b, bin
//   in_ready   unit can accept operands (IDLE)
//   a, b, bin  minuend, subtrahend, borrow-in (sampled at the accept edge only)
//   out_valid  diff/bout hold a completed result (DONE)
//   out_ready  consumer accepts the result
//   diff, bout difference and borrow-out
//   busy       operation in progress (SHIFT or DONE)
module serial_sub_unit #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             brw_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ brw;
    brw_next = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & brw) | (b_sh[0] & brw);
    // New bit enters at the MSB so that after WIDTH shifts the LSB-first
    // stream lands in natural bit order; written this way to stay legal
    // for WIDTH=1.
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            brw    <= bin;
            res_sh <= '0;
            cnt    <= CNT_LOAD;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          brw    <= brw_next;
          cnt    <= cnt - CW'(1);
          if (cnt == CNT_LAST) begin
            diff  <= res_next;
            bout  <= brw_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_sub_unit.sv
// Bench for serial_sub_unit: one WIDTH=2 and one WIDTH=8 instance, randomized
// and directed operations checked against an arithmetic reference model.
module tb_serial_sub_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       use8 = 1'b0;
  logic       in_valid_drv = 1'b0;
  logic       out_ready_drv = 1'b1;
  logic [7:0] a_drv = '0;
  logic [7:0] b_drv = '0;
  logic       bin_drv = 1'b0;

  logic       in_ready2, out_valid2, bout2, busy2;
  logic [1:0] diff2;
  logic       in_ready8, out_valid8, bout8, busy8;
  logic [7:0] diff8;

  logic       in_ready_m, out_valid_m, bout_m, busy_m;
  logic [7:0] diff_m;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_sub_unit #(.WIDTH(2)) u_sub2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_drv & ~use8), .in_ready(in_ready2),
    .a(a_drv[1:0]), .b(b_drv[1:0]), .bin(bin_drv),
    .out_valid(out_valid2), .out_ready(out_ready_drv),
    .diff(diff2), .bout(bout2), .busy(busy2)
  );

  serial_sub_unit #(.WIDTH(8)) u_sub8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_drv & use8), .in_ready(in_ready8),
    .a(a_drv), .b(b_drv), .bin(bin_drv),
    .out_valid(out_valid8), .out_ready(out_ready_drv),
    .diff(diff8), .bout(bout8), .busy(busy8)
  );

  assign in_ready_m  = use8 ? in_ready8  : in_ready2;
  assign out_valid_m = use8 ? out_valid8 : out_valid2;
  assign bout_m      = use8 ? bout8      : bout2;
  assign busy_m      = use8 ? busy8      : busy2;
  assign diff_m      = use8 ? diff8      : {6'b0, diff2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model(input int w, input int a, input int b, input int bin,
                                output int d, output int bo);
    int m;
    m  = 1 << w;
    d  = (((a - b - bin) % m) + m) % m;
    bo = (a < b + bin) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation and returns once out_valid is seen (before the
  // handshake edge). Operand inputs are scrambled while the unit is busy.
  task automatic do_op(input int a, input int b, input int bin,
                       output int got_d, output int got_bo);
    int w, lat, ed, eb;
    w = use8 ? 8 : 2;
    a_drv = 8'(a); b_drv = 8'(b); bin_drv = 1'(bin);
    in_valid_drv = 1'b1;
    check("in_ready_before_accept", 32'(in_ready_m), 1);
    tick();
    in_valid_drv = 1'b0;
    check("busy_after_accept", 32'(busy_m), 1);
    lat = 0;
    while (!out_valid_m && lat < 40) begin
      a_drv = 8'($urandom); b_drv = 8'($urandom); bin_drv = 1'($urandom);
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(w));
    model(w, a, b, bin, ed, eb);
    got_d  = int'(diff_m);
    got_bo = int'(bout_m);
    check("diff", 32'(got_d), 32'(ed));
    check("bout", 32'(got_bo), 32'(eb));
  endtask

  initial begin
    int d, bo, ra, rb, rbin;

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      use8 = s[0];
      #1;
      check("rst_in_ready", 32'(in_ready_m), 1);
      check("rst_out_valid", 32'(out_valid_m), 0);
      check("rst_busy", 32'(busy_m), 0);
      check("rst_diff", 32'(diff_m), 0);
      check("rst_bout", 32'(bout_m), 0);
    end

    // WIDTH=2 exhaustive, back to back with out_ready=1
    use8 = 1'b0;
    out_ready_drv = 1'b1;
    for (int i = 0; i < 32; i++) begin
      do_op((i >> 3) & 3, (i >> 1) & 3, i & 1, d, bo);
      tick();
      check("idle_after_handshake", 32'(in_ready_m), 1);
    end

    // Spot checks
    do_op(3, 1, 0, d, bo); check("spot_3_1_0_diff", 32'(d), 2); check("spot_3_1_0_bout", 32'(bo), 0); tick();
    do_op(1, 2, 0, d, bo); check("spot_1_2_0_diff", 32'(d), 3); check("spot_1_2_0_bout", 32'(bo), 1); tick();
    do_op(0, 0, 1, d, bo); check("spot_0_0_1_diff", 32'(d), 3); check("spot_0_0_1_bout", 32'(bo), 1); tick();

    // Backpressure
    out_ready_drv = 1'b0;
    do_op(2, 1, 0, d, bo);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 32'(out_valid_m), 1);
      check("bp_diff_held", 32'(diff_m), 1);
      check("bp_in_ready", 32'(in_ready_m), 0);
      in_valid_drv = 1'b1;
      tick();
      in_valid_drv = 1'b0;
    end
    out_ready_drv = 1'b1;
    check("bp_before_hs", 32'(out_valid_m), 1);
    tick();
    check("bp_idle_after_hs", 32'(in_ready_m), 1);
    check("bp_out_valid_low", 32'(out_valid_m), 0);
    check("bp_diff_kept", 32'(diff_m), 1);

    // Input instability (operands scrambled inside do_op)
    do_op(3, 3, 0, d, bo);
    check("unstable_diff", 32'(d), 0);
    check("unstable_bout", 32'(bo), 0);
    tick();

    // Reset mid-operation
    a_drv = 8'd3; b_drv = 8'd0; bin_drv = 1'b0;
    in_valid_drv = 1'b1;
    tick();
    in_valid_drv = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("abort_no_out_valid", 32'(out_valid_m), 0);
      tick();
    end
    check("abort_idle", 32'(in_ready_m), 1);
    check("abort_busy", 32'(busy_m), 0);
    check("abort_diff", 32'(diff_m), 0);
    do_op(1, 1, 0, d, bo);
    check("post_abort_diff", 32'(d), 0);
    check("post_abort_bout", 32'(bo), 0);
    tick();

    // WIDTH=8
    use8 = 1'b1;
    #1;
    do_op(0, 0, 1, d, bo);
    check("w8_0_0_1_diff", 32'(d), 255); check("w8_0_0_1_bout", 32'(bo), 1);
    tick();
    do_op(200, 55, 1, d, bo);
    check("w8_200_55_1_diff", 32'(d), 144); check("w8_200_55_1_bout", 32'(bo), 0);
    tick();
    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(255)); rb = int'($urandom_range(255)); rbin = int'($urandom_range(1));
      do_op(ra, rb, rbin, d, bo);
      tick();
      check("w8_next_accept_ready", 32'(in_ready_m), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
